rat_io_responder: RTL and testbench

RAT_IO_RESPONDER -- requirements
Module: rat_io_responder

---
 rtl/rat_io_pkg.sv | 19 +
 rtl/rat_io_responder_io_sync.sv | 28 ++
 rtl/rat_io_responder.sv | 118 +++++++++++
 tb/tb_rat_io_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rat_io_pkg.sv
// rat_io_pkg: port-id map, interrupt bit layout and control bit indices for the RAT I/O responder
package rat_io_pkg;
   localparam logic [7:0] PID_SW   = 8'h20;
   localparam logic [7:0] PID_BTN  = 8'h21;
   localparam logic [7:0] PID_LED  = 8'h40;
   localparam logic [7:0] PID_SSEG = 8'h81;
   localparam logic [7:0] PID_RLO  = 8'h90;
   localparam logic [7:0] PID_RHI  = 8'h91;
   localparam logic [7:0] PID_CTRL = 8'h92;
   localparam logic [7:0] PID_MASK = 8'hA0;
   localparam logic [7:0] PID_PEND = 8'hA1;
   localparam int IRQ_TMR_BIT = 0;
   localparam int IRQ_BTN_LSB = 1;
   localparam int CTRL_EN_BIT = 0;
   // Bits of mask/pending that exist: timer bit plus one per button
   function automatic logic [7:0] irq_valid(input int nbtn);
      irq_valid = 8'((1 << (nbtn + 1)) - 1);
   endfunction
endpackage

// File: rtl/rat_io_responder_io_sync.sv
// io_sync: multi-flop synchronizer with a rising-edge detect on the synchronized value
module io_sync #(
   parameter int W      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic [W-1:0] o_rise
);
   logic [STAGES-1:0][W-1:0] r_sync;
   logic [W-1:0]             r_dly;

   // Shift raw input through the sync chain; one extra flop remembers the last synced value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
         r_dly  <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_dly  <= r_sync[STAGES-1];
      end
   end

   assign o_q    = r_sync[STAGES-1];
   assign o_rise = r_sync[STAGES-1] & ~r_dly;
endmodule

// File: rtl/rat_io_responder.sv
// rat_io_responder: CPU port-mapped LEDs, seven-segment, switches, buttons, reload timer and interrupt controller
module rat_io_responder
   import rat_io_pkg::*;
#(
   parameter int NUM_BTN     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMER_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         port_id,
   input  logic [7:0]         out_port,
   input  logic               io_strb,
   output logic [7:0]         in_port,
   input  logic [7:0]         switches,
   input  logic [NUM_BTN-1:0] buttons,
   output logic [7:0]         leds,
   output logic [7:0]         sseg,
   output logic               int_req
);
   localparam logic [7:0] VALID = irq_valid(NUM_BTN);

   logic [7:0]         w_sw;
   logic [7:0]         w_sw_rise_unused;
   logic [NUM_BTN-1:0] w_btn;
   logic [NUM_BTN-1:0] w_btn_rise;
   logic [7:0]         r_leds;
   logic [7:0]         r_sseg;
   logic [7:0]         r_rld_lo;
   logic               r_en;
   logic [7:0]         r_mask;
   logic [7:0]         r_pend;
   logic [TIMER_W-1:0] r_reload;
   logic [TIMER_W-1:0] r_count;
   logic [TIMER_W-1:0] w_rld_new;
   logic               w_tmr_active;
   logic               w_expire;
   logic               w_rhi_wr;
   logic [7:0]         w_set;
   logic [7:0]         w_clr;

   io_sync #(.W(8), .STAGES(SYNC_STAGES)) u_sw_sync (
      .clk    (clk),
      .rst    (rst),
      .i_d    (switches),
      .o_q    (w_sw),
      .o_rise (w_sw_rise_unused)
   );

   io_sync #(.W(NUM_BTN), .STAGES(SYNC_STAGES)) u_btn_sync (
      .clk    (clk),
      .rst    (rst),
      .i_d    (buttons),
      .o_q    (w_btn),
      .o_rise (w_btn_rise)
   );

   assign w_rld_new    = TIMER_W'({out_port, r_rld_lo});
   assign w_rhi_wr     = io_strb && port_id == PID_RHI;
   assign w_tmr_active = r_en && r_reload != '0;
   assign w_expire     = w_tmr_active && r_count == '0;
   assign w_set        = 8'({w_btn_rise, w_expire});
   assign w_clr        = (io_strb && port_id == PID_PEND) ? out_port : 8'h00;
   assign leds         = r_leds;
   assign sseg         = r_sseg;
   assign int_req      = |(r_pend & r_mask);

   // CPU-writable configuration registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_leds   <= 8'h00;
         r_sseg   <= 8'h00;
         r_rld_lo <= 8'h00;
         r_en     <= 1'b0;
         r_mask   <= 8'h00;
      end else if (io_strb) begin
         if (port_id == PID_LED)  r_leds   <= out_port;
         if (port_id == PID_SSEG) r_sseg   <= out_port;
         if (port_id == PID_RLO)  r_rld_lo <= out_port;
         if (port_id == PID_CTRL) r_en     <= out_port[CTRL_EN_BIT];
         if (port_id == PID_MASK) r_mask   <= out_port & VALID;
      end
   end

   // Reload timer: a reload_hi write reloads both registers, otherwise count down and wrap on expiry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reload <= '0;
         r_count  <= '0;
      end else if (w_rhi_wr) begin
         r_reload <= w_rld_new;
         r_count  <= w_rld_new;
      end else if (w_tmr_active) begin
         r_count <= (r_count == '0) ? r_reload : r_count - TIMER_W'(1);
      end
   end

   // Pending bits: write-one-to-clear, with a same-cycle set event taking priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_pend <= 8'h00;
      else      r_pend <= ((r_pend & ~w_clr) | w_set) & VALID;
   end

   // Read mux is combinational so the CPU sees data in the same cycle it drives port_id
   always_comb begin
      in_port = 8'h00;
      case (port_id)
         PID_SW:   in_port = w_sw;
         PID_BTN:  in_port = 8'(w_btn);
         PID_LED:  in_port = r_leds;
         PID_SSEG: in_port = r_sseg;
         PID_CTRL: in_port = {7'b0, r_en};
         PID_MASK: in_port = r_mask;
         PID_PEND: in_port = r_pend;
         default:  in_port = 8'h00;
      endcase
   end
endmodule

// File: tb/tb_rat_io_responder.sv
// tb_rat_io_responder: directed self-checking bench for the RAT I/O responder
module tb_rat_io_responder;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       io_strb = 1'b0;
   logic [7:0] switches = 8'h00;
   logic [3:0] buttons = 4'h0;
   logic [7:0] in_port;
   logic [7:0] leds;
   logic [7:0] sseg;
   logic       int_req;
   int         checks = 0;
   int         errors = 0;

   rat_io_responder #(.NUM_BTN(4), .SYNC_STAGES(2), .TIMER_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .port_id  (port_id),
      .out_port (out_port),
      .io_strb  (io_strb),
      .in_port  (in_port),
      .switches (switches),
      .buttons  (buttons),
      .leds     (leds),
      .sseg     (sseg),
      .int_req  (int_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] id, input logic [7:0] d);
      port_id  = id;
      out_port = d;
      io_strb  = 1'b1;
      @(negedge clk);
      io_strb  = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
      port_id = id;
      #1;
      chk(tag, in_port, exp);
   endtask

   initial begin
      switches = 8'h3C;
      port_id  = 8'h20;
      #3;
      chk("rst_leds", leds, 8'h00);
      chk("rst_sseg", sseg, 8'h00);
      chk("rst_int", 8'(int_req), 8'h00);
      chk("rst_sw", in_port, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      tick(1);
      rd("sw_lat1", 8'h20, 8'h00);
      tick(1);
      rd("sw_sync", 8'h20, 8'h3C);
      wr(8'h40, 8'hA5);
      rd("led_rd", 8'h40, 8'hA5);
      chk("led_out", leds, 8'hA5);
      wr(8'h81, 8'h5A);
      rd("sseg_rd", 8'h81, 8'h5A);
      chk("sseg_out", sseg, 8'h5A);
      wr(8'h33, 8'hFF);
      rd("unmapped_rd", 8'h33, 8'h00);
      chk("unmapped_led", leds, 8'hA5);
      chk("unmapped_sseg", sseg, 8'h5A);
      rd("unmapped_mask", 8'hA0, 8'h00);
      wr(8'hA0, 8'hFF);
      rd("mask_valid", 8'hA0, 8'h1F);
      wr(8'hA0, 8'h00);
      wr(8'h92, 8'h01);
      rd("ctrl_rd", 8'h92, 8'h01);
      tick(8);
      rd("rld0_noevt", 8'hA1, 8'h00);
      wr(8'h92, 8'h00);
      wr(8'h90, 8'h04);
      wr(8'h91, 8'h00);
      wr(8'hA0, 8'h01);
      wr(8'h92, 8'h01);
      port_id = 8'hA1;
      tick(4);
      rd("tmr_pre", 8'hA1, 8'h00);
      chk("tmr_pre_int", 8'(int_req), 8'h00);
      tick(1);
      rd("tmr_exp1", 8'hA1, 8'h01);
      chk("tmr_exp1_int", 8'(int_req), 8'h01);
      out_port = 8'h01;
      io_strb  = 1'b1;
      tick(1);
      io_strb = 1'b0;
      rd("tmr_w1c", 8'hA1, 8'h00);
      chk("tmr_w1c_int", 8'(int_req), 8'h00);
      tick(3);
      rd("tmr_pre2", 8'hA1, 8'h00);
      tick(1);
      rd("tmr_exp2", 8'hA1, 8'h01);
      tick(4);
      out_port = 8'h01;
      io_strb  = 1'b1;
      tick(1);
      io_strb = 1'b0;
      rd("set_wins", 8'hA1, 8'h01);
      chk("set_wins_int", 8'(int_req), 8'h01);
      wr(8'h92, 8'h00);
      wr(8'hA1, 8'hFF);
      rd("tmr_off_clr", 8'hA1, 8'h00);
      wr(8'hA0, 8'h08);
      buttons[2] = 1'b1;
      tick(2);
      rd("btn_lat", 8'hA1, 8'h00);
      tick(1);
      rd("btn_pend", 8'hA1, 8'h08);
      chk("btn_int", 8'(int_req), 8'h01);
      rd("btn_sync", 8'h21, 8'h04);
      wr(8'hA1, 8'h08);
      rd("btn_clr", 8'hA1, 8'h00);
      chk("btn_clr_int", 8'(int_req), 8'h00);
      tick(5);
      rd("btn_hold", 8'hA1, 8'h00);
      buttons[2] = 1'b0;
      tick(5);
      rd("btn_fall", 8'hA1, 8'h00);
      buttons[0] = 1'b1;
      tick(3);
      rd("btn0_masked", 8'hA1, 8'h02);
      chk("btn0_masked_int", 8'(int_req), 8'h00);
      wr(8'hA0, 8'h0A);
      chk("unmask_int", 8'(int_req), 8'h01);
      buttons[0] = 1'b0;
      wr(8'hA1, 8'hFF);
      wr(8'hA0, 8'h00);
      wr(8'h40, 8'hFF);
      wr(8'h90, 8'h03);
      wr(8'h91, 8'h00);
      wr(8'hA0, 8'h01);
      wr(8'h92, 8'h01);
      tick(2);
      buttons[0] = 1'b1;
      #2;
      rst = 1'b0;
      port_id = 8'h40;
      #1;
      chk("arst_leds", leds, 8'h00);
      chk("arst_sseg", sseg, 8'h00);
      chk("arst_int", 8'(int_req), 8'h00);
      chk("arst_rd", in_port, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      tick(2);
      rd("hold_lat", 8'hA1, 8'h00);
      tick(1);
      rd("hold_edge", 8'hA1, 8'h02);
      tick(10);
      rd("post_rst_noevt", 8'hA1, 8'h02);
      rd("post_rst_ctrl", 8'h92, 8'h00);
      chk("post_rst_int", 8'(int_req), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
